// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and the PLL/core reset tree.
// master: the sequencer; slave: the PLL/board side that supplies lock and restart.
interface pll_lock_sequencer_if;
    logic       locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retries;
    logic       lock_lost;

    modport master (
        input  locked,
        input  restart,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retries,
        output lock_lost
    );

    modport slave (
        output locked,
        output restart,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retries,
        input  lock_lost
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, qualifies its lock flag and releases the core reset once lock has been
// stable; retries on timeout, gives up into FAULT, and re-sequences on lock loss.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_lock_sequencer_if.master   bus
);

    localparam int unsigned MaxA = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                   PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MaxCycles = (MaxA > LOCK_TIMEOUT_CYCLES) ? MaxA : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles);

    localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RESET_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      MaxRetries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllReset,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retries_q, retries_d;
    logic [1:0]      sync_q;
    logic            locked_s;
    logic            lock_lost_d;
    logic            pll_rst_q, sys_rst_q, ready_q, fault_q, lock_lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.locked};
        end
    end

    assign locked_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        retries_d   = retries_q;
        lock_lost_d = 1'b0;

        if (bus.restart) begin
            state_d   = StPllReset;
            retries_d = 4'd0;
        end else begin
            unique case (state_q)
                StPllReset: begin
                    if (cnt_q == PllRstLast) begin
                        state_d = StWaitLock;
                    end
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        if ({1'b0, retries_q} + 5'd1 == {1'b0, MaxRetries}) begin
                            retries_d = MaxRetries;
                            state_d   = StFault;
                        end else begin
                            retries_d = retries_q + 4'd1;
                            state_d   = StPllReset;
                        end
                    end
                end
                StStable: begin
                    // Lock loss wins over a simultaneous count completion.
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d   = StRun;
                        retries_d = 4'd0;
                    end
                end
                StRun: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d     = StPllReset;
                        lock_lost_d = 1'b1;
                    end
                end
                StFault: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = StPllReset;
                end
            endcase
        end

        // A restart re-runs the full reset window even when already in PLL_RESET.
        if (bus.restart || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllReset;
            cnt_q       <= '0;
            retries_q   <= 4'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            pll_rst_q   <= (state_d == StPllReset) || (state_d == StFault);
            sys_rst_q   <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retries   = retries_q;
    assign bus.lock_lost = lock_lost_q;

endmodule
